// File: rtl/reaction_timer.sv
// Drag-strip reaction timer: measures milliseconds from the green light to driver launch.
// It flags false starts (launch or red light before green) and runs that reach the ceiling.
module reaction_timer #(
  parameter int CLK_HZ = 50000000,
  parameter int MAX_MS = 9999
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic        GRN,
  input  logic        RED,
  input  logic        GO,
  input  logic        CLR,
  output logic [13:0] TIME_MS,
  output logic        VALID,
  output logic        FOUL,
  output logic        TIMEOUT,
  output logic        BUSY
);

  localparam int TICKS = CLK_HZ / 1000;
  localparam int PW    = $clog2(TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS - 1);
  localparam logic [13:0]   MAX_T      = 14'(MAX_MS);
  localparam logic [13:0]   MAX_M1     = 14'(MAX_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_TIMING = 3'd2,
    S_DONE   = 3'd3,
    S_FOULED = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [13:0]   time_ms_r, time_ms_s;
  logic          valid_r, valid_s, foul_r, foul_s;
  logic          timeout_r, timeout_s, busy_r, busy_s;

  logic          go_meta_r, go_sync_r, go_prev_r, go_ok_r, launch_r;
  logic [1:0]    fill_r;
  logic          grn_prev_r, green_r;

  // GO synchronizer and registered launch/green event detection.
  // go_ok_r stays low until a genuinely sampled low GO is seen, so a GO held through reset cannot launch.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      go_meta_r  <= 1'b0;
      go_sync_r  <= 1'b0;
      go_prev_r  <= 1'b0;
      fill_r     <= 2'b00;
      go_ok_r    <= 1'b0;
      launch_r   <= 1'b0;
      grn_prev_r <= 1'b0;
      green_r    <= 1'b0;
    end else begin
      go_meta_r  <= GO;
      go_sync_r  <= go_meta_r;
      go_prev_r  <= go_sync_r;
      fill_r     <= {fill_r[0], 1'b1};
      go_ok_r    <= go_ok_r | (fill_r[1] & ~go_sync_r);
      launch_r   <= go_ok_r & go_sync_r & ~go_prev_r;
      grn_prev_r <= GRN;
      green_r    <= GRN & ~grn_prev_r;
    end
  end

  // Next-state and next-output computation.
  always_comb begin
    state_s   = state_r;
    presc_s   = presc_r;
    time_ms_s = time_ms_r;
    valid_s   = valid_r;
    foul_s    = foul_r;
    timeout_s = timeout_r;
    busy_s    = busy_r;
    case (state_r)
      S_IDLE: begin
        if (CLR) begin
          state_s   = S_ARMED;
          presc_s   = '0;
          time_ms_s = 14'd0;
          valid_s   = 1'b0;
          foul_s    = 1'b0;
          timeout_s = 1'b0;
          busy_s    = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARMED: begin
        if (CLR) begin
          state_s   = S_ARMED;
          time_ms_s = 14'd0;
          valid_s   = 1'b0;
          foul_s    = 1'b0;
          timeout_s = 1'b0;
          busy_s    = 1'b1;
        end else if (launch_r || RED) begin
          // A launch coincident with green is still a zero-reaction foul.
          state_s   = S_FOULED;
          time_ms_s = 14'd0;
          foul_s    = 1'b1;
          busy_s    = 1'b0;
        end else if (green_r) begin
          state_s   = S_TIMING;
          presc_s   = '0;
          time_ms_s = 14'd0;
          busy_s    = 1'b1;
        end else begin
          state_s = S_ARMED;
        end
      end
      S_TIMING: begin
        if (CLR) begin
          state_s   = S_ARMED;
          presc_s   = '0;
          time_ms_s = 14'd0;
          valid_s   = 1'b0;
          timeout_s = 1'b0;
          busy_s    = 1'b1;
        end else if (launch_r) begin
          state_s = S_DONE;
          valid_s = 1'b1;
          busy_s  = 1'b0;
        end else if (presc_r == PRESC_LAST) begin
          presc_s = '0;
          if (time_ms_r >= MAX_M1) begin
            state_s   = S_DONE;
            time_ms_s = MAX_T;
            valid_s   = 1'b1;
            timeout_s = 1'b1;
            busy_s    = 1'b0;
          end else begin
            time_ms_s = time_ms_r + 14'd1;
          end
        end else begin
          presc_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      S_DONE, S_FOULED: begin
        if (CLR) begin
          state_s   = S_ARMED;
          presc_s   = '0;
          time_ms_s = 14'd0;
          valid_s   = 1'b0;
          foul_s    = 1'b0;
          timeout_s = 1'b0;
          busy_s    = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s   = S_IDLE;
        presc_s   = '0;
        time_ms_s = 14'd0;
        valid_s   = 1'b0;
        foul_s    = 1'b0;
        timeout_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State, prescaler and registered output flops.
  always_ff @(posedge CLOCK_50 or negedge RST) begin
    if (!RST) begin
      state_r   <= S_IDLE;
      presc_r   <= '0;
      time_ms_r <= 14'd0;
      valid_r   <= 1'b0;
      foul_r    <= 1'b0;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      presc_r   <= presc_s;
      time_ms_r <= time_ms_s;
      valid_r   <= valid_s;
      foul_r    <= foul_s;
      timeout_r <= timeout_s;
      busy_r    <= busy_s;
    end
  end

  assign TIME_MS = time_ms_r;
  assign VALID   = valid_r;
  assign FOUL    = foul_r;
  assign TIMEOUT = timeout_r;
  assign BUSY    = busy_r;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer at 4 clocks/ms with a 20 ms ceiling.
module tb_reaction_timer;

  logic        CLOCK_50 = 1'b0;
  logic        RST, GRN, RED, GO, CLR;
  logic [13:0] TIME_MS;
  logic        VALID, FOUL, TIMEOUT, BUSY;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic        grn, red, go, clr;
    int          cyc;
    logic [13:0] t;
    logic        v, f, to, b;
  } vec_t;

  vec_t vq[$];

  reaction_timer #(.CLK_HZ(4000), .MAX_MS(20)) dut (
    .CLOCK_50(CLOCK_50), .RST(RST), .GRN(GRN), .RED(RED), .GO(GO), .CLR(CLR),
    .TIME_MS(TIME_MS), .VALID(VALID), .FOUL(FOUL), .TIMEOUT(TIMEOUT), .BUSY(BUSY)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic add(input string n, input logic grn, input logic red, input logic go,
                     input logic clr, input int cyc, input logic [13:0] t,
                     input logic v, input logic f, input logic to, input logic b);
    vec_t e;
    e.name = n; e.grn = grn; e.red = red; e.go = go; e.clr = clr; e.cyc = cyc;
    e.t = t; e.v = v; e.f = f; e.to = to; e.b = b;
    vq.push_back(e);
  endtask

  task automatic chk(input string n, input logic [13:0] t, input logic v, input logic f,
                     input logic to, input logic b);
    tests++;
    if (TIME_MS !== t || VALID !== v || FOUL !== f || TIMEOUT !== to || BUSY !== b) begin
      fails++;
      $display("FAIL %s: got time=%0d valid=%b foul=%b timeout=%b busy=%b, want time=%0d valid=%b foul=%b timeout=%b busy=%b",
               n, TIME_MS, VALID, FOUL, TIMEOUT, BUSY, t, v, f, to, b);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  initial begin
    bit found;
    RST = 1'b0; GRN = 1'b0; RED = 1'b0; GO = 1'b0; CLR = 1'b0;
    step(3);
    chk("reset_state", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;

    //  name                grn   red   go    clr   cyc  time   v     f     to    busy
    add("idle_hold",        1'b0, 1'b0, 1'b0, 1'b0, 3,  14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add("clr_arms",         1'b0, 1'b0, 1'b0, 1'b1, 1,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("armed_hold",       1'b0, 1'b0, 1'b0, 1'b0, 2,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("green_to_timing",  1'b1, 1'b0, 1'b0, 1'b0, 2,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("grn_fall_ignored", 1'b0, 1'b0, 1'b0, 1'b0, 4,  14'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    add("red_in_timing",    1'b0, 1'b1, 1'b0, 1'b0, 4,  14'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    add("clr_abort",        1'b0, 1'b0, 1'b0, 1'b1, 1,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("red_in_armed",     1'b0, 1'b1, 1'b0, 1'b0, 1,  14'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("fouled_grn_hold",  1'b1, 1'b0, 1'b0, 1'b0, 3,  14'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("fouled_go_hold",   1'b1, 1'b0, 1'b1, 1'b0, 4,  14'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("clr_from_foul",    1'b0, 1'b0, 1'b0, 1'b1, 1,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("armed_again",      1'b0, 1'b0, 1'b0, 1'b0, 3,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("go_latency_n2",    1'b0, 1'b0, 1'b1, 1'b0, 3,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("false_start",      1'b0, 1'b0, 1'b1, 1'b0, 1,  14'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("false_grn_ignore", 1'b1, 1'b0, 1'b1, 1'b0, 3,  14'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("false_release",    1'b0, 1'b0, 1'b0, 1'b0, 3,  14'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("clr_rearm",        1'b0, 1'b0, 1'b0, 1'b1, 1,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("coinc_go_early",   1'b0, 1'b0, 1'b1, 1'b0, 2,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("coinc_events",     1'b1, 1'b0, 1'b1, 1'b0, 1,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("coinc_foul",       1'b1, 1'b0, 1'b1, 1'b0, 1,  14'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add("clr_held_armed",   1'b0, 1'b0, 1'b0, 1'b1, 3,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("to_green_event",   1'b1, 1'b0, 1'b0, 1'b0, 1,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("to_timing_entry",  1'b1, 1'b0, 1'b0, 1'b0, 1,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add("to_before_limit",  1'b1, 1'b0, 1'b0, 1'b0, 79, 14'd19, 1'b0, 1'b0, 1'b0, 1'b1);
    add("to_at_limit",      1'b1, 1'b0, 1'b0, 1'b0, 1,  14'd20, 1'b1, 1'b0, 1'b1, 1'b0);
    add("to_no_increment",  1'b1, 1'b0, 1'b0, 1'b0, 20, 14'd20, 1'b1, 1'b0, 1'b1, 1'b0);
    add("to_clr_clears",    1'b0, 1'b0, 1'b0, 1'b1, 1,  14'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      GRN = vq[i].grn; RED = vq[i].red; GO = vq[i].go; CLR = vq[i].clr;
      step(vq[i].cyc);
      chk(vq[i].name, vq[i].t, vq[i].v, vq[i].f, vq[i].to, vq[i].b);
    end

    // Normal run: GO rises 40 clocks after GRN, expect about 10 ms.
    CLR = 1'b0; GRN = 1'b1;
    repeat (40) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    GO = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1);
      if (VALID === 1'b1) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL normal_valid_wait: got valid=%b within 12 cycles, want valid=1", VALID);
    end
    tests++;
    if (TIME_MS < 14'd9 || TIME_MS > 14'd11) begin
      fails++;
      $display("FAIL normal_time: got time=%0d, want 10 +/- 1", TIME_MS);
    end
    tests++;
    if ({VALID, FOUL, TIMEOUT, BUSY} !== 4'b1000) begin
      fails++;
      $display("FAIL normal_flags: got v/f/to/b=%b, want 1000", {VALID, FOUL, TIMEOUT, BUSY});
    end
    step(10);
    tests++;
    if (TIME_MS < 14'd9 || TIME_MS > 14'd11 || VALID !== 1'b1) begin
      fails++;
      $display("FAIL normal_frozen: got time=%0d valid=%b, want 10 +/- 1 and valid=1", TIME_MS, VALID);
    end

    // Asynchronous reset while timing at 7 ms.
    GO = 1'b0; GRN = 1'b0; CLR = 1'b1;
    step(3);
    chk("rst_seq_armed", 14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    CLR = 1'b0; GRN = 1'b1;
    step(2);
    chk("rst_seq_timing", 14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(28);
    chk("rst_seq_at_7ms", 14'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 RST = 1'b0;
    #1 chk("rst_async", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    GO = 1'b1; GRN = 1'b0;
    step(2);
    chk("rst_held", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // GO held high across reset release must not launch.
    RST = 1'b1;
    step(1);
    chk("rst_release_idle", 14'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    CLR = 1'b1;
    step(1);
    CLR = 1'b0;
    step(10);
    chk("go_held_no_launch", 14'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    GO = 1'b0;
    step(4);
    GO = 1'b1;
    step(4);
    chk("go_rearmed_launch", 14'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
